// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA datapath blocks: FIFO address-width
// limits and a constant-foldable ceil(log2) used to size counters.
package ipsl_pcie_dma_pkg;

    localparam int FIFO_AW_MIN = 4;
    localparam int FIFO_AW_MAX = 10;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_fifo_ptr.sv
// Pointer bookkeeping for the SDP-RAM FIFO: write/read pointers with one
// extra wrap bit, RAM empty detection, and the registered s_ready, count and
// almost flags, all derived from the next-state pointers.
module ipsl_pcie_dma_fifo_ptr
    import ipsl_pcie_dma_pkg::*;
#(
    parameter  int ADDR_WIDTH = 6,
    parameter  int AFULL_TH   = (2 ** ADDR_WIDTH) - 4,
    parameter  int AEMPTY_TH  = 2,
    localparam int CNT_W      = clog2((2 ** ADDR_WIDTH) + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  load_i,
    input  logic                  m_valid_d_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  ram_empty_o,
    output logic                  s_ready_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]    AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]    AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] ram_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                s_ready_q, s_ready_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;

    // RAM is full when the wrap bits differ and the address bits match.
    function automatic logic ptr_full(input logic [ADDR_WIDTH:0] wp,
                                      input logic [ADDR_WIDTH:0] rp);
        return (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]) &&
               (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]);
    endfunction

    // Next-state pointers (flush wins) and the flags derived from them.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (load_i) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        ram_cnt_d = wr_ptr_d - rd_ptr_d;
        count_d   = CNT_W'(ram_cnt_d) + CNT_W'(m_valid_d_i);
        s_ready_d = !ptr_full(wr_ptr_d, rd_ptr_d);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);
    end

    // Pointer and status registers; s_ready stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign wr_addr_o      = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr_o      = rd_ptr_q[ADDR_WIDTH-1:0];
    assign ram_empty_o    = (wr_ptr_q == rd_ptr_q);
    assign s_ready_o      = s_ready_q;
    assign count_o        = count_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

endmodule

// File: rtl/ipsl_pcie_dma_sdpram_fifo.sv
// First-word-fall-through FIFO controller around an external distributed
// simple-dual-port RAM. The RAM read port is combinational; this block
// captures it into an output register so the consumer sees registered data.
module ipsl_pcie_dma_sdpram_fifo
    import ipsl_pcie_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 4,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    if ((ADDR_WIDTH < FIFO_AW_MIN) || (ADDR_WIDTH > FIFO_AW_MAX)) begin : g_bad_aw
        $error("ipsl_pcie_dma_sdpram_fifo: ADDR_WIDTH out of range");
    end

    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  ram_empty;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    // A push is blocked during flush so nothing reaches the RAM that cycle.
    assign push = s_valid & s_ready & ~flush;
    assign pop  = m_valid_q & m_ready;
    // Refill the output register whenever it is free or being drained.
    assign load = (~m_valid_q | pop) & ~ram_empty & ~flush;

    ipsl_pcie_dma_fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AFULL_TH   (AFULL_TH),
        .AEMPTY_TH  (AEMPTY_TH)
    ) u_ptr (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .push_i         (push),
        .load_i         (load),
        .m_valid_d_i    (m_valid_d),
        .wr_addr_o      (ram_wr_addr),
        .rd_addr_o      (ram_rd_addr),
        .ram_empty_o    (ram_empty),
        .s_ready_o      (s_ready),
        .count_o        (count),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
    );

    // Output-register next state; data only changes on a load.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = ram_rd_data;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign ram_wr_en   = push;
    assign ram_wr_data = s_data;

endmodule

// File: tb/tb_ipsl_pcie_dma_sdpram_fifo.sv
// Bench for ipsl_pcie_dma_sdpram_fifo with AW=4, DW=32 and a comb-read RAM.
module tb_ipsl_pcie_dma_sdpram_fifo;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    logic [DW-1:0] mem [0:(2**AW)-1];

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic [DW-1:0] q[$];
    bit            mv_m;
    bit            sr_m;
    bit            stall_p;
    logic [DW-1:0] data_p;

    ipsl_pcie_dma_sdpram_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AFULL_TH   (12),
        .AEMPTY_TH  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = mem[ram_rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_aempty"}, almost_empty, 1);
    endtask

    task automatic model_reset();
        q.delete();
        mv_m    = 1'b0;
        sr_m    = 1'b1;
        stall_p = 1'b0;
        data_p  = '0;
    endtask

    // One clock of stimulus with every output compared against the model.
    task automatic mcycle(input bit sv, input logic [DW-1:0] sd, input bit mr);
        bit push;
        bit pop;
        bit load;
        int ramc;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        check("s_ready", s_ready, sr_m);
        check("m_valid", m_valid, mv_m);
        check("count", count, q.size());
        check("almost_full", almost_full, q.size() >= 12);
        check("almost_empty", almost_empty, q.size() <= 2);
        if (mv_m) check("m_data", m_data, q[0]);
        if (stall_p) check("m_data_hold", m_data, data_p);
        push    = sv && sr_m;
        pop     = mv_m && mr;
        ramc    = q.size() - int'(mv_m);
        load    = (!mv_m || pop) && (ramc != 0);
        stall_p = mv_m && !mr;
        data_p  = mv_m ? q[0] : '0;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(sd);
        if (load) mv_m = 1'b1;
        else if (pop) mv_m = 1'b0;
        sr_m = (q.size() - int'(mv_m)) != 16;
        step();
    endtask

    task automatic model_drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) mcycle(1'b0, '0, 1'b1);
        check("drain_count", count, 0);
        check("drain_m_valid", m_valid, 0);
    endtask

    function automatic logic [DW-1:0] w2(input int i);
        return 32'h2000_0000 + DW'(i);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        int pv;
        int pr;

        // reset state
        repeat (2) step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();
        check("rst_rel_s_ready", s_ready, 1);
        check("rst_rel_m_valid", m_valid, 0);

        // single word, latency 2
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        check("t1_c1_m_valid", m_valid, 0);
        check("t1_c1_count", count, 1);
        step();
        check("t1_c2_m_valid", m_valid, 1);
        check("t1_c2_m_data", m_data, 32'hA5A5_0001);
        check("t1_c2_count", count, 1);
        step();
        check("t1_c3_m_valid", m_valid, 0);
        check("t1_c3_count", count, 0);
        check("t1_c3_aempty", almost_empty, 1);
        m_ready = 1'b0;

        // fill to 17 words with the consumer stalled
        for (int i = 1; i <= 17; i++) begin
            s_valid = 1'b1;
            s_data  = w2(i);
            check("fill_s_ready", s_ready, 1);
            step();
        end
        s_data = w2(18);
        check("full_s_ready", s_ready, 0);
        check("full_count", count, 17);
        check("full_afull", almost_full, 1);
        check("full_aempty", almost_empty, 0);
        check("full_m_valid", m_valid, 1);
        check("full_m_data", m_data, w2(1));
        check("full_wr_en", ram_wr_en, 0);
        step();
        check("full18_count", count, 17);
        check("full18_m_data", m_data, w2(1));
        s_valid = 1'b0;

        // single pop from full
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("pop1_m_data", m_data, w2(2));
        check("pop1_s_ready", s_ready, 1);
        check("pop1_count", count, 16);
        check("pop1_afull", almost_full, 1);
        step();
        check("pop1_hold", m_data, w2(2));
        m_ready = 1'b1;
        for (int j = 3; j <= 17; j++) begin
            step();
            check("drain_order", m_data, w2(j));
        end
        step();
        m_ready = 1'b0;
        check("drained_m_valid", m_valid, 0);
        check("drained_count", count, 0);

        // streaming through pointer wrap
        model_reset();
        bubbles = 0;
        for (int k = 0; k < 100; k++) begin
            if (k >= 2 && !m_valid) bubbles++;
            mcycle(1'b1, 32'h4000_0000 + DW'(k), 1'b1);
        end
        check("stream_bubbles", bubbles, 0);
        check("stream_tail_count", count, 2);
        model_drain();

        // random traffic
        for (int k = 0; k < 10000; k++) begin
            if (((k / 1000) % 2) == 0) begin
                pv = 80;
                pr = 30;
            end else begin
                pv = 30;
                pr = 80;
            end
            mcycle($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr);
        end
        model_drain();

        // flush with 5 words held and a push in the flush cycle
        for (int i = 0; i < 5; i++) mcycle(1'b1, 32'h6000_0000 + DW'(i), 1'b0);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        m_ready = 1'b0;
        #1;
        check("pre_flush_count", count, 5);
        check("flush_wr_en", ram_wr_en, 0);
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_m_valid", m_valid, 0);
        check("flush_s_ready", s_ready, 1);
        check("flush_aempty", almost_empty, 1);
        model_reset();
        mcycle(1'b1, 32'h7000_0001, 1'b1);
        mcycle(1'b0, '0, 1'b1);
        mcycle(1'b0, '0, 1'b1);
        mcycle(1'b0, '0, 1'b1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) mcycle(1'b1, 32'h8000_0000 + DW'(i), 1'b0);
        s_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        check("async_rst_wr_en", ram_wr_en, 0);
        s_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst2_s_ready", s_ready, 1);
        check("rst2_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
